// File: rtl/rv32i_rd_write_arbiter_pkg.sv
// Shared constants and types for the base-register write-port arbiter.
package rv32i_rd_write_arbiter_pkg;

    localparam int QUEUE_DEPTH_DEF  = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_FORCE = 2'd1,
        GRANT_WB    = 2'd2,
        GRANT_MC    = 2'd3
    } grant_e;

    function automatic logic [31:0] regOneHot(input logic [4:0] addr);
        return 32'd1 << addr;
    endfunction

endpackage

// File: rtl/rv32i_rd_write_arbiter_if.sv
// Writeback, multi-cycle result and basereg write-port signals of the arbiter.
interface rv32i_rd_write_arbiter_if;

    logic        i_wb_wr;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_mc_valid;
    logic        o_mc_ready;
    logic [4:0]  i_mc_addr;
    logic [31:0] i_mc_data;
    logic        o_wr;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_stall_wb;
    logic        o_busy;
    logic [31:0] o_pending_mask;

    modport master (
        output i_wb_wr, i_wb_addr, i_wb_data, i_mc_valid, i_mc_addr, i_mc_data,
        input  o_mc_ready, o_wr, o_wr_addr, o_wr_data, o_stall_wb, o_busy, o_pending_mask
    );

    modport slave (
        input  i_wb_wr, i_wb_addr, i_wb_data, i_mc_valid, i_mc_addr, i_mc_data,
        output o_mc_ready, o_wr, o_wr_addr, o_wr_data, o_stall_wb, o_busy, o_pending_mask
    );

endinterface

// File: rtl/rv32i_rd_result_fifo.sv
// Circular queue of multi-cycle results; entries can be invalidated in place
// by a younger writeback to the same register.
module rv32i_rd_result_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [4:0]            push_addr_i,
    input  logic [31:0]           push_data_i,
    input  logic                  pop_i,
    input  logic                  squash_i,
    input  logic [4:0]            squash_addr_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  head_valid_o,
    output logic [4:0]            head_addr_o,
    output logic [31:0]           head_data_o,
    output logic [DEPTH-1:0]      entry_valid_o,
    output logic [DEPTH-1:0][4:0] entry_addr_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0][4:0]   addr_q;
    logic [DEPTH-1:0][31:0]  data_q;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Squash first; the pushed slot is free and never carries the squashed address.
    always_comb begin
        valid_d = valid_q;
        if (squash_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == squash_addr_i) valid_d[i] = 1'b0;
            end
        end
        if (pop_i)  valid_d[rdPtr_q] = 1'b0;
        if (push_i) valid_d[wrPtr_q] = 1'b1;
    end

    always_comb begin
        rdPtr_d = pop_i  ? nextPtr(rdPtr_q) : rdPtr_q;
        wrPtr_d = push_i ? nextPtr(wrPtr_q) : wrPtr_q;
        count_d = count_q;
        if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
        else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            if (push_i) begin
                addr_q[wrPtr_q] <= push_addr_i;
                data_q[wrPtr_q] <= push_data_i;
            end
        end
    end

    assign count_o       = count_q;
    assign head_valid_o  = valid_q[rdPtr_q];
    assign head_addr_o   = addr_q[rdPtr_q];
    assign head_data_o   = data_q[rdPtr_q];
    assign entry_valid_o = valid_q;
    assign entry_addr_o  = addr_q;

endmodule

// File: rtl/rv32i_rd_write_arbiter.sv
// Shares the basereg write port between writeback (priority) and queued
// multi-cycle results, forcing a writeback stall when the queue head starves.
module rv32i_rd_write_arbiter
    import rv32i_rd_write_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH  = QUEUE_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    rv32i_rd_write_arbiter_if.slave  arb
);

    localparam int CNT_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]            count;
    logic                        headValid;
    logic [4:0]                  headAddr;
    logic [31:0]                 headData;
    logic [QUEUE_DEPTH-1:0]      entryValid;
    logic [QUEUE_DEPTH-1:0][4:0] entryAddr;

    logic [STARVE_W-1:0] starve_q, starve_d;
    grant_e              grant;
    logic                countNz, mcReady, accept, wbReq, starveFull;
    logic                push, pop, squash;
    logic [31:0]         pendingMask;

    assign countNz    = (count != '0);
    assign mcReady    = i_rst_n && (count != CNT_W'(QUEUE_DEPTH));
    assign accept     = arb.i_mc_valid && mcReady;
    assign wbReq      = arb.i_wb_wr && (arb.i_wb_addr != REG_X0);
    assign starveFull = (starve_q == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        grant = GRANT_NONE;
        if (!i_rst_n)                 grant = GRANT_NONE;
        else if (countNz && starveFull) grant = GRANT_FORCE;
        else if (wbReq)               grant = GRANT_WB;
        else if (countNz)             grant = GRANT_MC;
    end

    always_comb begin
        arb.o_wr       = 1'b0;
        arb.o_wr_addr  = '0;
        arb.o_wr_data  = '0;
        arb.o_stall_wb = 1'b0;
        pop            = 1'b0;
        unique case (grant)
            GRANT_FORCE: begin
                arb.o_wr       = headValid;
                arb.o_wr_addr  = headAddr;
                arb.o_wr_data  = headData;
                arb.o_stall_wb = 1'b1;
                pop            = 1'b1;
            end
            GRANT_WB: begin
                arb.o_wr      = 1'b1;
                arb.o_wr_addr = arb.i_wb_addr;
                arb.o_wr_data = arb.i_wb_data;
            end
            GRANT_MC: begin
                arb.o_wr      = headValid;
                arb.o_wr_addr = headAddr;
                arb.o_wr_data = headData;
                pop           = 1'b1;
            end
            default: ;
        endcase
    end

    // A same-cycle result to the register the writeback is writing is older, so it is dropped.
    assign squash = (grant == GRANT_WB);
    assign push   = accept && (arb.i_mc_addr != REG_X0) &&
                    !(squash && (arb.i_mc_addr == arb.i_wb_addr));

    always_comb begin
        starve_d = starve_q;
        if (!countNz || pop)                starve_d = '0;
        else if (headValid && !starveFull)  starve_d = starve_q + STARVE_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end

    rv32i_rd_result_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i         (i_clk),
        .rst_ni        (i_rst_n),
        .push_i        (push),
        .push_addr_i   (arb.i_mc_addr),
        .push_data_i   (arb.i_mc_data),
        .pop_i         (pop),
        .squash_i      (squash),
        .squash_addr_i (arb.i_wb_addr),
        .count_o       (count),
        .head_valid_o  (headValid),
        .head_addr_o   (headAddr),
        .head_data_o   (headData),
        .entry_valid_o (entryValid),
        .entry_addr_o  (entryAddr)
    );

    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (entryValid[i]) pendingMask = pendingMask | regOneHot(entryAddr[i]);
        end
    end

    assign arb.o_pending_mask = pendingMask;
    assign arb.o_busy         = countNz;
    assign arb.o_mc_ready     = mcReady;

endmodule

// File: tb/tb_rv32i_rd_write_arbiter.sv
// Directed scoreboard bench for rv32i_rd_write_arbiter (QUEUE_DEPTH=2, STARVE_LIMIT=4).
module tb_rv32i_rd_write_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    rv32i_rd_write_arbiter_if arb ();

    rv32i_rd_write_arbiter #(
        .QUEUE_DEPTH  (2),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .arb     (arb)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d, input logic s);
        expQ.push_back(exp_t'{addr: a, data: d, stall: s});
    endtask

    // Drives one cycle of inputs just after the rising edge and returns mid-cycle.
    task automatic applyStimulus(input logic wbWr, input logic [4:0] wbAddr, input logic [31:0] wbData,
                                 input logic mcValid, input logic [4:0] mcAddr, input logic [31:0] mcData);
        @(posedge clk);
        #1;
        arb.i_wb_wr    = wbWr;
        arb.i_wb_addr  = wbAddr;
        arb.i_wb_data  = wbData;
        arb.i_mc_valid = mcValid;
        arb.i_mc_addr  = mcAddr;
        arb.i_mc_data  = mcData;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: every write on the port must match the next expected write in order.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (arb.o_wr === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: actual addr=%0d data=0x%08h required no write",
                             arb.o_wr_addr, arb.o_wr_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wr_addr",  32'(arb.o_wr_addr),  32'(e.addr));
                    checkOutput("wr_data",  arb.o_wr_data,       e.data);
                    checkOutput("wr_stall", 32'(arb.o_stall_wb), 32'(e.stall));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : stimulus
        rst_n          = 1'b0;
        arb.i_wb_wr    = 1'b0;
        arb.i_wb_addr  = '0;
        arb.i_wb_data  = '0;
        arb.i_mc_valid = 1'b0;
        arb.i_mc_addr  = '0;
        arb.i_mc_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wr",      32'(arb.o_wr),       32'd0);
        checkOutput("rst_addr",    32'(arb.o_wr_addr),  32'd0);
        checkOutput("rst_data",    arb.o_wr_data,       32'd0);
        checkOutput("rst_stall",   32'(arb.o_stall_wb), 32'd0);
        checkOutput("rst_busy",    32'(arb.o_busy),     32'd0);
        checkOutput("rst_mask",    arb.o_pending_mask,  32'd0);
        checkOutput("rst_ready",   32'(arb.o_mc_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(arb.o_mc_ready), 32'd1);

        $display("[TB] writeback only");
        expectWrite(5'd5, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        checkOutput("wb_stall", 32'(arb.o_stall_wb), 32'd0);
        // Writeback to x0 never writes and never stalls.
        applyStimulus(1'b1, 5'd0, 32'h0BAD_0BAD, 1'b0, 5'd0, 32'd0);
        checkOutput("x0_stall", 32'(arb.o_stall_wb), 32'd0);

        $display("[TB] multi-cycle only");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_1234);
        checkOutput("mc_busy_before", 32'(arb.o_busy), 32'd0);
        expectWrite(5'd7, 32'h0000_1234, 1'b0);
        idleCycle();
        checkOutput("mc_busy",  32'(arb.o_busy),    32'd1);
        checkOutput("mc_mask",  arb.o_pending_mask, 32'h0000_0080);
        idleCycle();
        checkOutput("mc_busy_clear", 32'(arb.o_busy),    32'd0);
        checkOutput("mc_mask_clear", arb.o_pending_mask, 32'd0);

        $display("[TB] starvation");
        expectWrite(5'd9, 32'h0000_0900, 1'b0);
        applyStimulus(1'b1, 5'd9, 32'h0000_0900, 1'b1, 5'd3, 32'h0000_0033);
        for (int i = 1; i <= 4; i++) begin
            expectWrite(5'd9, 32'h0000_0900 + 32'(i), 1'b0);
            applyStimulus(1'b1, 5'd9, 32'h0000_0900 + 32'(i), 1'b0, 5'd0, 32'd0);
        end
        expectWrite(5'd3, 32'h0000_0033, 1'b1);
        applyStimulus(1'b1, 5'd9, 32'h0000_0905, 1'b0, 5'd0, 32'd0);
        checkOutput("starve_stall", 32'(arb.o_stall_wb), 32'd1);
        expectWrite(5'd9, 32'h0000_0905, 1'b0);
        applyStimulus(1'b1, 5'd9, 32'h0000_0905, 1'b0, 5'd0, 32'd0);
        idleCycle();

        $display("[TB] WAW squash");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_AAAA);
        expectWrite(5'd10, 32'h0000_BBBB, 1'b0);
        applyStimulus(1'b1, 5'd10, 32'h0000_BBBB, 1'b1, 5'd10, 32'h0000_CCCC);
        checkOutput("waw_mask_set", arb.o_pending_mask, 32'h0000_0400);
        idleCycle();
        checkOutput("waw_mask_clear", arb.o_pending_mask, 32'd0);
        checkOutput("waw_busy_dead",  32'(arb.o_busy),    32'd1);
        idleCycle();
        checkOutput("waw_busy_clear", 32'(arb.o_busy), 32'd0);

        $display("[TB] full queue");
        expectWrite(5'd1, 32'h0000_0100, 1'b0);
        applyStimulus(1'b1, 5'd1, 32'h0000_0100, 1'b1, 5'd20, 32'h0000_2020);
        expectWrite(5'd1, 32'h0000_0101, 1'b0);
        applyStimulus(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd21, 32'h0000_2121);
        expectWrite(5'd1, 32'h0000_0102, 1'b0);
        applyStimulus(1'b1, 5'd1, 32'h0000_0102, 1'b1, 5'd22, 32'h0000_2222);
        checkOutput("full_ready", 32'(arb.o_mc_ready), 32'd0);
        expectWrite(5'd1, 32'h0000_0103, 1'b0);
        applyStimulus(1'b1, 5'd1, 32'h0000_0103, 1'b1, 5'd22, 32'h0000_2222);
        expectWrite(5'd1, 32'h0000_0104, 1'b0);
        applyStimulus(1'b1, 5'd1, 32'h0000_0104, 1'b1, 5'd22, 32'h0000_2222);
        expectWrite(5'd20, 32'h0000_2020, 1'b1);
        applyStimulus(1'b1, 5'd1, 32'h0000_0105, 1'b1, 5'd22, 32'h0000_2222);
        checkOutput("full_ready_on_pop", 32'(arb.o_mc_ready), 32'd0);
        expectWrite(5'd21, 32'h0000_2121, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h0000_2222);
        checkOutput("full_ready_again", 32'(arb.o_mc_ready), 32'd1);
        expectWrite(5'd22, 32'h0000_2222, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("full_busy_clear", 32'(arb.o_busy), 32'd0);

        $display("[TB] reset mid-operation");
        expectWrite(5'd2, 32'h0000_0200, 1'b0);
        applyStimulus(1'b1, 5'd2, 32'h0000_0200, 1'b1, 5'd11, 32'h0000_1111);
        expectWrite(5'd2, 32'h0000_0201, 1'b0);
        applyStimulus(1'b1, 5'd2, 32'h0000_0201, 1'b1, 5'd12, 32'h0000_1212);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        arb.i_wb_data  = 32'h0000_0202;
        arb.i_mc_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_wr",    32'(arb.o_wr),       32'd0);
        checkOutput("midrst_stall", 32'(arb.o_stall_wb), 32'd0);
        checkOutput("midrst_busy",  32'(arb.o_busy),     32'd0);
        checkOutput("midrst_mask",  arb.o_pending_mask,  32'd0);
        checkOutput("midrst_ready", 32'(arb.o_mc_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        arb.i_wb_wr    = 1'b0;
        arb.i_wb_addr  = '0;
        arb.i_wb_data  = '0;
        @(negedge clk);
        checkOutput("postrst_ready", 32'(arb.o_mc_ready), 32'd1);
        checkOutput("postrst_busy",  32'(arb.o_busy),     32'd0);
        repeat (3) idleCycle();

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
